// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store engine with misaligned splitting, bus timeout and fault causes.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter bit SPLIT_MISALIGNED = 1,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  input  logic [31:0]       store_data,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_fault,
  output logic [1:0]        resp_cause,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;
  state_t state;
  logic [ADDR_W-1:0] a_in, a_q, word_addr;
  logic [2:0] f3_q;
  logic st_q, split_q, fault_q, illegal, mis, reject, acc, timeout;
  logic [1:0] cause_q;
  logic [31:0] sd_q, rd1_q, data_q, cnt, ld, ld_ext;
  logic [7:0] be8;
  logic [63:0] wd64;
  logic [4:0] sh;
  assign a_in = base + offset;
  assign illegal = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (is_store && funct3[2]);
  assign mis = (funct3[1:0] == 2'b01 && a_in[1:0] == 2'b11) || (funct3[1:0] == 2'b10 && a_in[1:0] != 2'b00);
  assign reject = illegal || (mis && !SPLIT_MISALIGNED);
  assign acc = state == ACC1 || state == ACC2;
  assign sh = {a_q[1:0], 3'b000};
  // Lane masks and data span two words; the upper half belongs to the second access of a split.
  assign be8 = (f3_q[1:0] == 2'b00 ? 8'h01 : f3_q[1:0] == 2'b01 ? 8'h03 : 8'h0F) << a_q[1:0];
  assign wd64 = {32'b0, sd_q} << sh;
  assign word_addr = {a_q[ADDR_W-1:2], 2'b00} + (state == ACC2 ? ADDR_W'(4) : '0);
  assign ld = 32'({mem_rdata, state == ACC2 ? rd1_q : mem_rdata} >> sh);
  assign ld_ext = f3_q == 3'b000 ? {{24{ld[7]}}, ld[7:0]} :
                  f3_q == 3'b001 ? {{16{ld[15]}}, ld[15:0]} :
                  f3_q == 3'b100 ? {24'b0, ld[7:0]} :
                  f3_q == 3'b101 ? {16'b0, ld[15:0]} : ld;
  assign timeout = TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);
  assign req_ready = state == IDLE && !rst;
  assign resp_valid = state == RESP;
  assign resp_data = resp_valid ? data_q : '0;
  assign resp_fault = resp_valid && fault_q;
  assign resp_cause = resp_valid ? cause_q : '0;
  assign mem_addr = acc ? word_addr : '0;
  assign mem_re = acc && !st_q;
  assign mem_we = acc && st_q;
  assign mem_be = !acc ? '0 : state == ACC2 ? be8[7:4] : be8[3:0];
  assign mem_wdata = !acc ? '0 : state == ACC2 ? wd64[63:32] : wd64[31:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      data_q <= '0;
      fault_q <= 1'b0;
      cause_q <= '0;
      a_q <= '0;
      f3_q <= '0;
      st_q <= 1'b0;
      split_q <= 1'b0;
      sd_q <= '0;
      rd1_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_q <= a_in;
          f3_q <= funct3;
          st_q <= is_store;
          sd_q <= store_data;
          split_q <= mis;
          cnt <= '0;
          data_q <= '0;
          fault_q <= reject;
          cause_q <= illegal ? 2'd3 : reject ? 2'd1 : 2'd0;
          state <= reject ? RESP : ACC1;
        end
        ACC1, ACC2: if (mem_ack) begin
          cnt <= '0;
          if (state == ACC1 && split_q) begin
            rd1_q <= mem_rdata;
            state <= ACC2;
          end else begin
            data_q <= st_q ? '0 : ld_ext;
            state <= RESP;
          end
        end else if (timeout) begin
          fault_q <= 1'b1;
          cause_q <= 2'd2;
          data_q <= '0;
          state <= RESP;
        end else cnt <= cnt + 32'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed tests for load_store_unit (32-bit split, 28-bit split, 32-bit no-split).
module tb_load_store_unit;
  logic clk = 0, rst = 1, is_store = 0, mem_ack = 0, v0 = 0, v1 = 0, v2 = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] base = 0, offset = 0, store_data = 0, mem_rdata = 0;
  logic rdy0, rv0, rf0, re0, we0, rdy1, rv1, rf1, re1, we1, rdy2, rv2, rf2, re2, we2;
  logic [1:0] rc0, rc1, rc2;
  logic [3:0] be0, be1, be2;
  logic [31:0] rd0, rd1, rd2, ma0, ma2, wd0, wd1, wd2;
  logic [27:0] ma1;
  int pass_n = 0, total_n = 0;
  always #5 clk = ~clk;
  load_store_unit #(.ADDR_W(32), .SPLIT_MISALIGNED(1), .TIMEOUT(16)) u0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data), .resp_valid(rv0), .resp_data(rd0),
    .resp_fault(rf0), .resp_cause(rc0), .mem_addr(ma0), .mem_re(re0), .mem_we(we0), .mem_be(be0),
    .mem_wdata(wd0), .mem_rdata(mem_rdata), .mem_ack(mem_ack));
  load_store_unit #(.ADDR_W(28), .SPLIT_MISALIGNED(1), .TIMEOUT(16)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .is_store(is_store), .funct3(funct3),
    .base(base[27:0]), .offset(offset[27:0]), .store_data(store_data), .resp_valid(rv1), .resp_data(rd1),
    .resp_fault(rf1), .resp_cause(rc1), .mem_addr(ma1), .mem_re(re1), .mem_we(we1), .mem_be(be1),
    .mem_wdata(wd1), .mem_rdata(mem_rdata), .mem_ack(mem_ack));
  load_store_unit #(.ADDR_W(32), .SPLIT_MISALIGNED(0), .TIMEOUT(16)) u2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data), .resp_valid(rv2), .resp_data(rd2),
    .resp_fault(rf2), .resp_cause(rc2), .mem_addr(ma2), .mem_re(re2), .mem_we(we2), .mem_be(be2),
    .mem_wdata(wd2), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int u, input logic st, input logic [2:0] f, input logic [31:0] b, o, d);
    is_store = st; funct3 = f; base = b; offset = o; store_data = d;
    v0 = (u == 0); v1 = (u == 1); v2 = (u == 2);
    tick();
    v0 = 0; v1 = 0; v2 = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    total_n++; if (rdy0 !== 1'b0) $display("FAIL reset_ready got %b want 0", rdy0); else pass_n++;
    total_n++; if ({rv0, re0, we0, rf0} !== 4'b0) $display("FAIL reset_strobes got %b want 0000", {rv0, re0, we0, rf0}); else pass_n++;
    total_n++; if ({ma0, be0, wd0, rd0} !== 100'b0) $display("FAIL reset_buses got %h want 0", {ma0, be0, wd0, rd0}); else pass_n++;
    rst = 0; tick();
    total_n++; if (rdy0 !== 1'b1) $display("FAIL post_reset_ready got %b want 1", rdy0); else pass_n++;
  endtask

  task automatic test_lw();
    issue(0, 0, 3'b010, 32'h100, 32'h4, 0);
    total_n++; if ({re0, we0, rdy0} !== 3'b100) $display("FAIL lw_strobe got %b want 100", {re0, we0, rdy0}); else pass_n++;
    total_n++; if (ma0 !== 32'h104) $display("FAIL lw_addr got %h want 00000104", ma0); else pass_n++;
    total_n++; if (be0 !== 4'hF) $display("FAIL lw_be got %h want f", be0); else pass_n++;
    mem_ack = 1; mem_rdata = 32'hDEADBEEF; tick(); mem_ack = 0;
    total_n++; if ({rv0, rf0, re0, rdy0} !== 4'b1000) $display("FAIL lw_resp_flags got %b want 1000", {rv0, rf0, re0, rdy0}); else pass_n++;
    total_n++; if (rd0 !== 32'hDEADBEEF) $display("FAIL lw_data got %h want deadbeef", rd0); else pass_n++;
    tick();
    total_n++; if ({rv0, rdy0} !== 2'b01) $display("FAIL lw_after got %b want 01", {rv0, rdy0}); else pass_n++;
  endtask

  task automatic test_split_load();
    issue(0, 0, 3'b001, 32'h100, 32'h3, 0);
    total_n++; if ({ma0, be0, re0} !== {32'h100, 4'h8, 1'b1}) $display("FAIL lh_part1 got %h/%h/%b want 100/8/1", ma0, be0, re0); else pass_n++;
    mem_ack = 1; mem_rdata = 32'h80AABBCC; tick();
    total_n++; if ({ma0, be0, re0, rv0} !== {32'h104, 4'h1, 2'b10}) $display("FAIL lh_part2 got %h/%h/%b/%b want 104/1/1/0", ma0, be0, re0, rv0); else pass_n++;
    mem_rdata = 32'h11223380; tick(); mem_ack = 0;
    total_n++; if ({rv0, rf0, rd0} !== {2'b10, 32'hFFFF8080}) $display("FAIL lh_data got %b/%b/%h want 1/0/ffff8080", rv0, rf0, rd0); else pass_n++;
    tick();
  endtask

  task automatic test_sub_word_loads();
    issue(0, 0, 3'b000, 32'h100, 32'h1, 0);
    total_n++; if ({ma0, be0} !== {32'h100, 4'h2}) $display("FAIL lb_bus got %h/%h want 100/2", ma0, be0); else pass_n++;
    mem_ack = 1; mem_rdata = 32'h11228033; tick(); mem_ack = 0;
    total_n++; if (rd0 !== 32'hFFFFFF80) $display("FAIL lb_data got %h want ffffff80", rd0); else pass_n++;
    tick();
    issue(0, 0, 3'b101, 32'h100, 32'h2, 0);
    total_n++; if (be0 !== 4'hC) $display("FAIL lhu_be got %h want c", be0); else pass_n++;
    mem_ack = 1; mem_rdata = 32'h9ABC0000; tick(); mem_ack = 0;
    total_n++; if (rd0 !== 32'h00009ABC) $display("FAIL lhu_data got %h want 00009abc", rd0); else pass_n++;
    tick();
  endtask

  task automatic test_split_store_wrap();
    issue(1, 1, 3'b010, 32'h0FFFFFFE, 32'h0, 32'h11223344);
    total_n++; if ({we1, ma1, be1, wd1} !== {1'b1, 28'hFFFFFFC, 4'hC, 32'h33440000}) $display("FAIL sw_part1 got %b/%h/%h/%h want 1/ffffffc/c/33440000", we1, ma1, be1, wd1); else pass_n++;
    mem_ack = 1; tick();
    total_n++; if ({we1, ma1, be1, wd1} !== {1'b1, 28'h0, 4'h3, 32'h00001122}) $display("FAIL sw_part2 got %b/%h/%h/%h want 1/0000000/3/00001122", we1, ma1, be1, wd1); else pass_n++;
    tick(); mem_ack = 0;
    total_n++; if ({rv1, rf1, rd1} !== {2'b10, 32'h0}) $display("FAIL sw_resp got %b/%b/%h want 1/0/0", rv1, rf1, rd1); else pass_n++;
    tick();
  endtask

  task automatic test_sb_wait();
    issue(0, 1, 3'b000, 32'h200, 32'h2, 32'hA5);
    for (int i = 0; i < 4; i++) begin
      total_n++; if ({we0, be0, wd0, rv0} !== {1'b1, 4'h4, 32'h00A50000, 1'b0}) $display("FAIL sb_wait%0d got %b/%h/%h/%b want 1/4/00a50000/0", i, we0, be0, wd0, rv0); else pass_n++;
      if (i == 3) mem_ack = 1;
      tick();
    end
    mem_ack = 0;
    total_n++; if ({rv0, we0, rf0} !== 3'b100) $display("FAIL sb_resp got %b want 100", {rv0, we0, rf0}); else pass_n++;
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    issue(0, 0, 3'b010, 32'h100, 32'h0, 0);
    for (int i = 0; i < 40 && !rv0; i++) begin
      if (re0) n++;
      tick();
    end
    total_n++; if (rv0 !== 1'b1) $display("FAIL to_resp got %b want 1", rv0); else pass_n++;
    total_n++; if (n != 16) $display("FAIL to_strobe_cycles got %0d want 16", n); else pass_n++;
    total_n++; if ({rf0, rc0, rd0} !== {1'b1, 2'd2, 32'h0}) $display("FAIL to_fault got %b/%0d/%h want 1/2/0", rf0, rc0, rd0); else pass_n++;
    tick();
  endtask

  task automatic test_faults();
    issue(2, 0, 3'b010, 32'h100, 32'h1, 0);
    total_n++; if ({rv2, rf2, rc2, re2} !== {2'b11, 2'd1, 1'b0}) $display("FAIL misal_fault got %b/%b/%0d/%b want 1/1/1/0", rv2, rf2, rc2, re2); else pass_n++;
    tick();
    issue(0, 1, 3'b100, 32'h100, 32'h0, 32'hFF);
    total_n++; if ({rv0, rf0, rc0, we0} !== {2'b11, 2'd3, 1'b0}) $display("FAIL illegal_store got %b/%b/%0d/%b want 1/1/3/0", rv0, rf0, rc0, we0); else pass_n++;
    tick();
    issue(2, 0, 3'b011, 32'h100, 32'h1, 0);
    total_n++; if ({rv2, rc2} !== {1'b1, 2'd3}) $display("FAIL illegal_precedence got %b/%0d want 1/3", rv2, rc2); else pass_n++;
    tick();
  endtask

  task automatic test_reset_mid();
    issue(0, 0, 3'b010, 32'h300, 32'h0, 0);
    total_n++; if (re0 !== 1'b1) $display("FAIL rmid_strobe got %b want 1", re0); else pass_n++;
    tick();
    rst = 1; tick();
    total_n++; if ({re0, rv0, rdy0} !== 3'b000) $display("FAIL rmid_drop got %b want 000", {re0, rv0, rdy0}); else pass_n++;
    rst = 0; mem_ack = 1; mem_rdata = 32'h55555555; tick(); mem_ack = 0;
    total_n++; if ({re0, rv0, rdy0} !== 3'b001) $display("FAIL rmid_late_ack got %b want 001", {re0, rv0, rdy0}); else pass_n++;
  endtask

  task automatic test_back_to_back();
    issue(0, 0, 3'b010, 32'h400, 32'h0, 0);
    mem_ack = 1; mem_rdata = 32'h12345678; tick(); mem_ack = 0;
    total_n++; if ({rv0, rdy0, rd0} !== {2'b10, 32'h12345678}) $display("FAIL b2b_first got %b/%b/%h want 1/0/12345678", rv0, rdy0, rd0); else pass_n++;
    tick();
    total_n++; if (rdy0 !== 1'b1) $display("FAIL b2b_ready got %b want 1", rdy0); else pass_n++;
    issue(0, 0, 3'b010, 32'h400, 32'h4, 0);
    total_n++; if (ma0 !== 32'h404) $display("FAIL b2b_addr got %h want 00000404", ma0); else pass_n++;
    mem_ack = 1; mem_rdata = 32'hCAFEF00D; tick(); mem_ack = 0;
    total_n++; if ({rv0, rd0} !== {1'b1, 32'hCAFEF00D}) $display("FAIL b2b_second got %b/%h want 1/cafef00d", rv0, rd0); else pass_n++;
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_split_load();
    test_sub_word_loads();
    test_split_store_wrap();
    test_sb_wait();
    test_timeout();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store engine for the RV32 core. It takes one decoded memory operation at a time from execute, computes the effective address, and drives a word-aligned strobe/ack data-bus port. Compared with the fixed single-access controller, it splits misaligned halfword/word accesses into two bus transactions (when enabled), times out stalled bus cycles, and reports faults with a cause code instead of hanging.

## Interface
- ADDR_W, 32: effective/bus address width; address arithmetic is mod 2^ADDR_W.
- SPLIT_MISALIGNED, 1: 1 = split misaligned accesses into two bus accesses; 0 = fault them.
- TIMEOUT, 16: max cycles a strobe waits for mem_ack; 0 disables the timeout.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  operation offered.
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- base  in  ADDR_W  rs1 value.
- offset  in  ADDR_W  sign-extended immediate.
- store_data  in  32  rs2 value; low bytes used for B/H.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  load result, extended per funct3; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid.
- resp_cause  out  2  0 none, 1 misaligned, 2 bus timeout, 3 illegal op.
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] always 0.
- mem_re  out  1  read strobe, level, held until ack.
- mem_we  out  1  write strobe, level, held until ack.
- mem_be  out  4  byte lane enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  completes the current strobe.

## Operation
- States: IDLE, ACC1, ACC2, RESP. All request fields are registered on accept.
- Effective address a = base + offset, truncated to ADDR_W. Size s is 1, 2 or 4; lane o = a[1:0].
- Illegal op: funct3 011/110/111, or a store with 100/101. Transition IDLE→RESP with no bus access and cause 3.
- Misaligned: (s==2 && o==3) || (s==4 && o!=0). Precedence is illegal op, then misaligned.
  - SPLIT_MISALIGNED=0: IDLE→RESP, cause 1, no bus access.
  - SPLIT_MISALIGNED=1: ACC1 accesses word a&~3 with lanes o..3. ACC2 accesses word (a&~3)+4 (wraps to 0 at the top of the address space) with lanes 0..(o+s-5).
- Aligned access: ACC1 only. mem_be = ((1<<s)-1)<<o, and mem_wdata = store_data<<(8o).
- Split store: first part mem_wdata = store_data<<(8o); second part = store_data>>(8(4-o)).
- Load assembly:
  - First part contributes mem_rdata>>(8o) in the low (4-o) bytes.
  - Second part fills the bytes above those.
  - Then sign- (B/H) or zero- (BU/HU) extend from bit 8s-1. W is unmodified.
- ACCn: strobe (mem_re or mem_we) is high with stable addr/be/wdata until a cycle in which mem_ack=1. On that edge go to ACC2 (split, first part) or RESP.
- Timeout: a counter clears on entering each ACCn and counts every cycle without ack. When it reaches TIMEOUT, drop the strobe and go to RESP with cause 2. A timeout in ACC2 of a split store leaves the first part written; this is architectural, and software handles it via the fault.
- RESP: resp_valid=1 for one cycle, then IDLE.
- mem_ack outside ACCn is ignored. mem_rdata is captured only when mem_ack=1.

## Timing
- Reset values: req_ready=0 during reset and 1 from the first cycle after. Every other output is 0.
- Reset mid-operation returns to IDLE on that edge: strobes drop, the transaction is discarded, and no resp_valid is produced.
- Aligned, ack in the first strobe cycle: accept at cycle 0, strobe cycle 1, resp_valid cycle 2. Each wait cycle adds 1.
- Split with immediate acks: resp_valid at cycle 3. Fault without bus access: resp_valid at cycle 1.
- req_ready=0 from accept through the RESP cycle. The next accept is possible the cycle after RESP.
- mem_ack in the same cycle the strobe first rises is legal and completes that access.

## Test plan
- LW base=0x100, offset=4, ack immediate, rdata=0xDEADBEEF → mem_addr=0x104, be=F; resp_data=0xDEADBEEF at cycle 2, fault=0.
- LH a=0x103 split, rdata word0=0x80AABBCC, word1=0x11223380 → accesses 0x100 be=8 then 0x104 be=1; resp_data=0xFFFF8080.
- SW a=0x0FFFFFFE (ADDR_W=28) data=0x11223344 split → 0xFFFFFFC be=C wdata=0x33440000, then 0x0000000 be=3 wdata=0x00001122.
- SB a=0x202 data=0xA5 with ack delayed 3 cycles → mem_we held 4 cycles, be=4, wdata=0x00A50000; resp_valid 5 cycles after accept.
- LW with no ack, TIMEOUT=16 → strobe high exactly 16 cycles, resp_fault=1, cause=2, resp_data=0. SPLIT_MISALIGNED=0 LW a=0x101 → cause 1 at cycle 1, no strobe.
- Store funct3=100 → cause 3, no strobe. rst asserted during an ACC1 wait → strobe low next cycle, no resp_valid, a late ack is ignored, and a new LW completes normally.
